machine_timer: RTL

- Memory-mapped machine timer and software-interrupt source (CLINT-style) for a single hart.
- Sits directly upstream of the privileged/CSR stage and drives its `irq_timer_i` and `irq_software_i` inputs. Those inputs land in mip.MTIP and mip.MSIP.
- Accessed by the LSU through a simple single-cycle-request, fixed-latency data-bus port.

---
 rtl/machine_timer.sv | 74 +++++++
 1 files changed

// File: rtl/machine_timer.sv
// machine_timer: CLINT-style mtime/mtimecmp/msip block for a single hart,
// with a fixed one-cycle bus response and registered timer interrupt.
module machine_timer #(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        irq_timer_o,
    output logic        irq_software_o
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] pre;
    logic [63:0]   mtime, mtimecmp, mtime_nxt, cmp_nxt;
    logic [31:0]   mask, rd;
    logic [2:0]    idx;
    logic          msip, tick, wr, unused_addr;

    assign idx         = addr_i[4:2];
    assign wr          = req_i & we_i;
    assign tick        = pre == PW'(TICK_DIV - 1);
    assign mask        = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
    assign unused_addr = ^addr_i[1:0];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [31:0] m);
        return (old & ~m) | (d & m);
    endfunction

    // A bus write to either mtime half replaces this cycle's increment entirely.
    always_comb begin
        mtime_nxt = tick ? mtime + 64'd1 : mtime;
        cmp_nxt   = mtimecmp;
        if (wr && idx == 3'd0) mtime_nxt = {mtime[63:32], merge(mtime[31:0], wdata_i, mask)};
        if (wr && idx == 3'd1) mtime_nxt = {merge(mtime[63:32], wdata_i, mask), mtime[31:0]};
        if (wr && idx == 3'd2) cmp_nxt = {mtimecmp[63:32], merge(mtimecmp[31:0], wdata_i, mask)};
        if (wr && idx == 3'd3) cmp_nxt = {merge(mtimecmp[63:32], wdata_i, mask), mtimecmp[31:0]};
        rd = idx == 3'd0 ? mtime[31:0] :
             idx == 3'd1 ? mtime[63:32] :
             idx == 3'd2 ? mtimecmp[31:0] :
             idx == 3'd3 ? mtimecmp[63:32] :
             idx == 3'd4 ? {31'b0, msip} : 32'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre         <= '0;
            mtime       <= '0;
            mtimecmp    <= RESET_CMP;
            msip        <= 1'b0;
            rvalid_o    <= 1'b0;
            rdata_o     <= '0;
            irq_timer_o <= 1'b0;
        end else begin
            pre         <= tick ? '0 : pre + PW'(1);
            mtime       <= mtime_nxt;
            mtimecmp    <= cmp_nxt;
            if (wr && idx == 3'd4 && be_i[0]) msip <= wdata_i[0];
            rvalid_o    <= req_i;
            rdata_o     <= (req_i && !we_i) ? rd : 32'b0;
            irq_timer_o <= mtime >= mtimecmp;
        end
    end

    assign irq_software_o = msip;
endmodule
